// File: rtl/step_sequencer.sv
// step_sequencer
//   Steps through NUM_STEPS steps. Step i lasts dwell[i]+1 cycles. The dwell
//   table is written through the cfg_* port while the sequencer is not running.
//   A sequence either finishes (done strobe) or wraps back to step 0 when
//   loop_mode is set. It can be aborted with halt (aborted strobe).
//
// Ports
//   __clk      : sole clock, all state changes on its rising edge
//   __rst_n    : synchronous active-low reset (also clears the dwell table)
//   start      : begin a sequence, honoured only while idle
//   halt       : abort a running sequence (wins over start and step ends)
//   loop_mode  : wrap from the last step to step 0 instead of finishing
//   cfg_we     : dwell table write strobe
//   cfg_idx    : dwell table entry to write
//   cfg_dwell  : dwell value to write
//   state      : FSM state code (0 idle, 1 run, 2 done)
//   step_idx   : current step number
//   step_pulse : strobe on the final cycle of each step
//   busy       : high while running
//   done       : strobe for the single done cycle
//   aborted    : strobe in the idle cycle that follows a halt
//   cfg_err    : strobe in the cycle after a rejected table write
module step_sequencer #(
  parameter int NUM_STEPS = 4,
  parameter int CNT_WIDTH = 8,
  parameter int IDX_WIDTH = 2
) (
  input  logic                 __clk,
  input  logic                 __rst_n,
  input  logic                 start,
  input  logic                 halt,
  input  logic                 loop_mode,
  input  logic                 cfg_we,
  input  logic [IDX_WIDTH-1:0] cfg_idx,
  input  logic [CNT_WIDTH-1:0] cfg_dwell,
  output logic [7:0]           state,
  output logic [IDX_WIDTH-1:0] step_idx,
  output logic                 step_pulse,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted,
  output logic                 cfg_err
);

  // Table address width: just enough bits to address NUM_STEPS entries.
  localparam int AW = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;

  localparam logic [7:0] ST_IDLE = 8'd0;
  localparam logic [7:0] ST_RUN  = 8'd1;
  localparam logic [7:0] ST_DONE = 8'd2;

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_STEPS - 1);
  localparam logic [AW-1:0]        ADDR0    = '0;

  logic [7:0]           state_q, state_d;
  logic [IDX_WIDTH-1:0] step_idx_q, load_idx;
  logic [AW-1:0]        load_addr, cfg_addr;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] dwell [NUM_STEPS];
  logic                 aborted_q, cfg_err_q;
  logic                 step_end, last_step, cfg_idx_ok, cfg_accept;

  // A step ends when its counter has reached zero. A halt in the same cycle
  // takes priority, so the step end (and its pulse) does not happen.
  assign step_end   = (state_q == ST_RUN) && !halt && (cnt_q == '0);
  assign last_step  = (step_idx_q == LAST_IDX);
  assign load_idx   = last_step ? '0 : step_idx_q + IDX_WIDTH'(1);
  assign load_addr  = load_idx[AW-1:0];
  assign cfg_addr   = cfg_idx[AW-1:0];
  assign cfg_idx_ok = (33'(cfg_idx) < 33'(NUM_STEPS));
  assign cfg_accept = cfg_we && (state_q != ST_RUN) && cfg_idx_ok;

  // State register
  always_ff @(posedge __clk) begin
    if (!__rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start && !halt) state_d = ST_RUN;
      ST_RUN: begin
        if (halt)                                 state_d = ST_IDLE;
        else if (step_end && last_step && !loop_mode) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from the current state
  always_comb begin
    busy       = (state_q == ST_RUN);
    done       = (state_q == ST_DONE);
    step_pulse = step_end;
  end

  // Step index, dwell counter, dwell table and registered strobes
  always_ff @(posedge __clk) begin
    if (!__rst_n) begin
      step_idx_q <= '0;
      cnt_q      <= '0;
      aborted_q  <= 1'b0;
      cfg_err_q  <= 1'b0;
      for (int i = 0; i < NUM_STEPS; i++) dwell[i] <= '0;
    end else begin
      aborted_q <= (state_q == ST_RUN) && halt;
      cfg_err_q <= cfg_we && !cfg_accept;
      if (cfg_accept) dwell[cfg_addr] <= cfg_dwell;

      unique case (state_q)
        ST_IDLE: begin
          if (start && !halt) begin
            step_idx_q <= '0;
            cnt_q      <= dwell[ADDR0];
          end
        end
        ST_RUN: begin
          if (halt) begin
            step_idx_q <= '0;
            cnt_q      <= '0;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_WIDTH'(1);
          end else if (!last_step || loop_mode) begin
            // Advance to the next step, or wrap to step 0 in loop mode.
            step_idx_q <= load_idx;
            cnt_q      <= dwell[load_addr];
          end else begin
            // Sequence complete; park the index at 0 for the done cycle.
            step_idx_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign state    = state_q;
  assign step_idx = step_idx_q;
  assign aborted  = aborted_q;
  assign cfg_err  = cfg_err_q;

endmodule

// File: tb/tb_step_sequencer.sv
module tb_step_sequencer;

  localparam int NS = 4;

  logic       __clk = 1'b0;
  logic       __rst_n, start, halt, loop_mode, cfg_we;
  logic [1:0] cfg_idx;
  logic [7:0] cfg_dwell;

  logic [7:0] state, state3;
  logic [1:0] step_idx, step_idx3;
  logic       step_pulse, busy, done, aborted, cfg_err;
  logic       step_pulse3, busy3, done3, aborted3, cfg_err3;

  always #5 __clk = ~__clk;

  step_sequencer u_dut (
    .__clk(__clk), .__rst_n(__rst_n), .start(start), .halt(halt),
    .loop_mode(loop_mode), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_dwell(cfg_dwell), .state(state), .step_idx(step_idx),
    .step_pulse(step_pulse), .busy(busy), .done(done),
    .aborted(aborted), .cfg_err(cfg_err)
  );

  step_sequencer #(.NUM_STEPS(3), .CNT_WIDTH(8), .IDX_WIDTH(2)) u_dut3 (
    .__clk(__clk), .__rst_n(__rst_n), .start(start), .halt(halt),
    .loop_mode(loop_mode), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_dwell(cfg_dwell), .state(state3), .step_idx(step_idx3),
    .step_pulse(step_pulse3), .busy(busy3), .done(done3),
    .aborted(aborted3), .cfg_err(cfg_err3)
  );

  wire [14:0] obs  = {state, step_idx, step_pulse, busy, done, aborted, cfg_err};
  wire [14:0] obs3 = {state3, step_idx3, step_pulse3, busy3, done3, aborted3, cfg_err3};

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: dwell table contents and the per-cycle step trace
  // of a sequence started from it.
  int mdl [NS];
  int tr_idx [$];
  bit tr_pulse [$];

  function automatic logic [14:0] ev(int st, int idx, bit p, bit b, bit d, bit a, bit e);
    logic [7:0] s8;
    logic [1:0] i2;
    s8 = st[7:0];
    i2 = idx[1:0];
    return {s8, i2, p, b, d, a, e};
  endfunction

  // Each step s is dwell[s]+1 cycles long, the pulse falls on its last one.
  function automatic void build_trace(int ns, bit lp, int maxlen);
    int s;
    tr_idx.delete();
    tr_pulse.delete();
    s = 0;
    while (tr_idx.size() < maxlen) begin
      for (int c = 0; c <= mdl[s]; c++) begin
        tr_idx.push_back(s);
        tr_pulse.push_back(c == mdl[s]);
      end
      s++;
      if (s == ns) begin
        if (!lp) break;
        s = 0;
      end
    end
  endfunction

  task automatic tick();
    @(posedge __clk);
    #1;
  endtask

  task automatic load_table(int a, int b, int c, int d);
    int v [NS];
    v = '{a, b, c, d};
    for (int i = 0; i < NS; i++) begin
      cfg_we = 1'b1; cfg_idx = i[1:0]; cfg_dwell = v[i][7:0];
      tick();
      mdl[i] = v[i];
    end
    cfg_we = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    __rst_n = 1'b0; start = 1'b1;
    tick(); tick();
    n_checks++;
    if ({obs, obs3} !== {ev(0, 0, 0, 0, 0, 0, 0), ev(0, 0, 0, 0, 0, 0, 0)}) begin
      n_fail++;
      $display("FAIL reset_state: got %h/%h expected all-idle", obs, obs3);
    end
    __rst_n = 1'b1; start = 1'b0;
    tick();
    n_checks++;
    if (obs !== ev(0, 0, 0, 0, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL start_in_reset_ignored: got %h expected %h", obs, ev(0, 0, 0, 0, 0, 0, 0));
    end
    for (int i = 0; i < NS; i++) mdl[i] = 0;
  endtask

  // Table {2,0,1,3}, single pass; start and halt held in the done cycle.
  task automatic test_single_pass();
    int len;
    int pc [$];
    logic [14:0] e;
    load_table(2, 0, 1, 3);
    build_trace(NS, 1'b0, 1000);
    len = tr_idx.size();
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 1; k <= len + 3; k++) begin
      start = (k == len + 1); halt = (k == len + 1);
      #1;
      if (k <= len)          e = ev(1, tr_idx[k-1], tr_pulse[k-1], 1, 0, 0, 0);
      else if (k == len + 1) e = ev(2, 0, 0, 0, 1, 0, 0);
      else                   e = ev(0, 0, 0, 0, 0, 0, 0);
      if (step_pulse) pc.push_back(k);
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL single_pass cycle %0d: got %h expected %h", k, obs, e);
      end
      if (k < len + 3) tick();
    end
    start = 1'b0; halt = 1'b0;
    n_checks++;
    if (!(pc.size() == 4 && pc[0] == 3 && pc[1] == 4 && pc[2] == 6 && pc[3] == 10)) begin
      n_fail++;
      $display("FAIL pulse_cycles: got %0d pulses %p expected 3,4,6,10", pc.size(), pc);
    end
    tick();
  endtask

  // Same table looping; halt lands on the final cycle of step 1 (cycle 14).
  task automatic test_loop_halt();
    logic [14:0] e;
    loop_mode = 1'b1;
    build_trace(NS, 1'b1, 20);
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      halt = (k == 14);
      #1;
      if (k <= 14)      e = ev(1, tr_idx[k-1], tr_pulse[k-1] && (k != 14), 1, 0, 0, 0);
      else if (k == 15) e = ev(0, 0, 0, 0, 0, 1, 0);
      else              e = ev(0, 0, 0, 0, 0, 0, 0);
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL loop_halt cycle %0d: got %h expected %h", k, obs, e);
      end
      if (k < 16) tick();
    end
    halt = 1'b0; loop_mode = 1'b0;
    tick();
  endtask

  // A freshly reset table gives four one-cycle steps then done.
  task automatic test_zero_table();
    logic [14:0] e;
    __rst_n = 1'b0; tick(); __rst_n = 1'b1; tick();
    for (int i = 0; i < NS; i++) mdl[i] = 0;
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      if (k <= 4)      e = ev(1, k - 1, 1, 1, 0, 0, 0);
      else if (k == 5) e = ev(2, 0, 0, 0, 1, 0, 0);
      else             e = ev(0, 0, 0, 0, 0, 0, 0);
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL zero_table cycle %0d: got %h expected %h", k, obs, e);
      end
      tick();
    end
  endtask

  // Write attempt to entry 1 while busy must be rejected; rerun proves it.
  task automatic test_cfg_busy();
    int len;
    logic [14:0] e;
    load_table(1, 2, 0, 1);
    build_trace(NS, 1'b0, 1000);
    len = tr_idx.size();
    for (int p = 0; p < 2; p++) begin
      start = 1'b1; tick(); start = 1'b0;
      for (int k = 1; k <= len + 2; k++) begin
        cfg_we = (p == 0) && (k == 2); cfg_idx = 2'd1; cfg_dwell = 8'd7;
        #1;
        if (k <= len)          e = ev(1, tr_idx[k-1], tr_pulse[k-1], 1, 0, 0, (p == 0) && (k == 3));
        else if (k == len + 1) e = ev(2, 0, 0, 0, 1, 0, 0);
        else                   e = ev(0, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (obs !== e) begin
          n_fail++;
          $display("FAIL cfg_busy pass %0d cycle %0d: got %h expected %h", p, k, obs, e);
        end
        tick();
      end
      cfg_we = 1'b0;
    end
  endtask

  // Out-of-range index on the 3-step instance: rejected, table untouched.
  task automatic test_cfg_range();
    int len;
    logic [14:0] e;
    __rst_n = 1'b0; tick(); __rst_n = 1'b1; tick();
    load_table(1, 2, 0, 3);
    cfg_we = 1'b1; cfg_idx = 2'd3; cfg_dwell = 8'd9;
    tick();
    cfg_we = 1'b0;
    mdl[3] = 9;
    n_checks++;
    if ({cfg_err3, cfg_err} !== 2'b10) begin
      n_fail++;
      $display("FAIL cfg_range_err: got %b expected 10", {cfg_err3, cfg_err});
    end
    tick();
    n_checks++;
    if ({cfg_err3, cfg_err} !== 2'b00) begin
      n_fail++;
      $display("FAIL cfg_range_err_clear: got %b expected 00", {cfg_err3, cfg_err});
    end
    build_trace(3, 1'b0, 1000);
    len = tr_idx.size();
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 1; k <= len + 2; k++) begin
      if (k <= len)          e = ev(1, tr_idx[k-1], tr_pulse[k-1], 1, 0, 0, 0);
      else if (k == len + 1) e = ev(2, 0, 0, 0, 1, 0, 0);
      else                   e = ev(0, 0, 0, 0, 0, 0, 0);
      n_checks++;
      if (obs3 !== e) begin
        n_fail++;
        $display("FAIL cfg_range_run cycle %0d: got %h expected %h", k, obs3, e);
      end
      tick();
    end
    repeat (20) tick();
    n_checks++;
    if (obs !== ev(0, 0, 0, 0, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL cfg_range_main_idle: got %h expected %h", obs, ev(0, 0, 0, 0, 0, 0, 0));
    end
  endtask

  task automatic test_start_halt();
    start = 1'b1; halt = 1'b1;
    tick();
    start = 1'b0; halt = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      n_checks++;
      if (obs !== ev(0, 0, 0, 0, 0, 0, 0)) begin
        n_fail++;
        $display("FAIL start_halt cycle %0d: got %h expected %h", k, obs, ev(0, 0, 0, 0, 0, 0, 0));
      end
      tick();
    end
  endtask

  task automatic test_random();
    int len, h, last;
    bit lp;
    logic [14:0] e;
    for (int it = 0; it < 8; it++) begin
      load_table($urandom_range(0, 5), $urandom_range(0, 5),
                 $urandom_range(0, 5), $urandom_range(0, 5));
      lp = $urandom_range(0, 1);
      build_trace(NS, lp, 40);
      len = tr_idx.size();
      if (lp || $urandom_range(0, 1) == 1) h = $urandom_range(1, len);
      else                                 h = 0;
      last = (h != 0) ? h + 2 : len + 2;
      loop_mode = lp;
      start = 1'b1; tick(); start = 1'b0;
      for (int k = 1; k <= last; k++) begin
        halt = (k == h);
        #1;
        if (h != 0 && k > h)   e = ev(0, 0, 0, 0, 0, (k == h + 1), 0);
        else if (k <= len)     e = ev(1, tr_idx[k-1], tr_pulse[k-1] && (k != h), 1, 0, 0, 0);
        else if (k == len + 1) e = ev(2, 0, 0, 0, 1, 0, 0);
        else                   e = ev(0, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (obs !== e) begin
          n_fail++;
          $display("FAIL random it %0d cycle %0d: got %h expected %h", it, k, obs, e);
        end
        tick();
      end
      halt = 1'b0; loop_mode = 1'b0;
    end
  endtask

  // Reset in the middle of step 2, then a run that shows the table is zero.
  task automatic test_reset_mid();
    logic [14:0] e;
    load_table(3, 3, 3, 3);
    build_trace(NS, 1'b0, 1000);
    start = 1'b1; tick(); start = 1'b0;
    repeat (8) tick();
    n_checks++;
    if (obs !== ev(1, tr_idx[8], tr_pulse[8], 1, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL reset_mid_pre: got %h expected %h", obs, ev(1, tr_idx[8], tr_pulse[8], 1, 0, 0, 0));
    end
    __rst_n = 1'b0; tick(); __rst_n = 1'b1;
    n_checks++;
    if (obs !== ev(0, 0, 0, 0, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL reset_mid_state: got %h expected %h", obs, ev(0, 0, 0, 0, 0, 0, 0));
    end
    for (int i = 0; i < NS; i++) mdl[i] = 0;
    build_trace(NS, 1'b0, 1000);
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      if (k <= 4)      e = ev(1, tr_idx[k-1], tr_pulse[k-1], 1, 0, 0, 0);
      else if (k == 5) e = ev(2, 0, 0, 0, 1, 0, 0);
      else             e = ev(0, 0, 0, 0, 0, 0, 0);
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL reset_mid_table cycle %0d: got %h expected %h", k, obs, e);
      end
      tick();
    end
  endtask

  initial begin
    __rst_n = 1'b0; start = 1'b0; halt = 1'b0; loop_mode = 1'b0;
    cfg_we = 1'b0; cfg_idx = '0; cfg_dwell = '0;
    tick();
    test_reset();
    test_single_pass();
    test_loop_halt();
    test_zero_table();
    test_cfg_busy();
    test_cfg_range();
    test_start_halt();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/step_sequencer.md
STEP_SEQUENCER -- requirements
Module: step_sequencer

Interface
REQ-001 The module SHALL have parameter NUM_STEPS, default 4, number of sequencer steps (legal 2..256).
REQ-002 The module SHALL have parameter CNT_WIDTH, default 8, width of each per-step dwell count.
REQ-003 The module SHALL have parameter IDX_WIDTH, default 2, width of step index (>= clog2(NUM_STEPS), min 1).
REQ-004 __clk  input  1  sole clock; all state changes on posedge __clk.
REQ-005 __rst_n  input  1  synchronous, active-low reset, sampled on posedge __clk.
REQ-006 start  input  1  begin a sequence; honoured only in StIdle.
REQ-007 halt  input  1  abort a running sequence.
REQ-008 loop_mode  input  1  1 = wrap from last step back to step 0 instead of finishing; sampled each cycle.
REQ-009 cfg_we  input  1  write strobe for dwell table.
REQ-010 cfg_idx  input  IDX_WIDTH  dwell table entry to write.
REQ-011 cfg_dwell  input  CNT_WIDTH  dwell value to write.
REQ-012 state  output  8  current FSM state code.
REQ-013 step_idx  output  IDX_WIDTH  current step number.
REQ-014 step_pulse  output  1  one-cycle strobe on the final cycle of each step.
REQ-015 busy  output  1  high while state is StRun.
REQ-016 done  output  1  one-cycle strobe when a sequence completes normally.
REQ-017 aborted  output  1  one-cycle strobe when halt terminates a sequence.
REQ-018 cfg_err  output  1  one-cycle strobe when a cfg write is rejected.

Function
REQ-019 State codes SHALL be 8-bit: StIdle=8'd0, StRun=8'd1, StDone=8'd2; all other codes unreachable.
REQ-020 Dwell table SHALL hold NUM_STEPS entries of CNT_WIDTH bits; step i SHALL last dwell[i]+1 cycles (dwell 0 = 1 cycle).
REQ-021 A dwell counter of CNT_WIDTH bits SHALL count down; no wrap below zero.
REQ-022 StIdle, start=1, halt=0: next cycle state=StRun, step_idx=0, counter=dwell[0], busy=1.
REQ-023 StIdle, start=1 and halt=1 same cycle: halt wins, remain StIdle, no strobes.
REQ-024 StRun, halt=0, counter!=0: counter decrements by 1; step_idx unchanged.
REQ-025 StRun, halt=0, counter==0: step_pulse=1 that cycle (registered-output equivalent: visible on the cycle counter reads 0).
REQ-026 Same cycle as REQ-025, step_idx<NUM_STEPS-1: next step_idx=step_idx+1, counter=dwell[step_idx+1].
REQ-027 Same cycle as REQ-025, step_idx==NUM_STEPS-1, loop_mode=0: next state=StDone.
REQ-028 Same cycle as REQ-025, step_idx==NUM_STEPS-1, loop_mode=1: next step_idx=0, counter=dwell[0], remain StRun.
REQ-029 StDone SHALL last exactly one cycle with done=1, busy=0, then StIdle; start during StDone ignored.
REQ-030 StRun with halt=1: next state=StIdle, aborted=1 for one cycle in that StIdle cycle, step_idx=0; halt overrides step-end events, step_pulse suppressed that cycle.
REQ-031 halt in StIdle or StDone SHALL have no effect.
REQ-032 cfg_we=1 in StIdle or StDone with cfg_idx<NUM_STEPS SHALL write dwell[cfg_idx]=cfg_dwell, visible to a start in the following cycle.
REQ-033 cfg_we=1 while busy=1, or cfg_idx>=NUM_STEPS, SHALL leave the table unchanged and assert cfg_err next cycle for one cycle.
REQ-034 Strobes (step_pulse, done, aborted, cfg_err) SHALL never be high two consecutive cycles from the same event.

Reset
REQ-035 __rst_n=0 SHALL force state=StIdle, step_idx=0, counter=0, all strobes=0, busy=0, all dwell entries=0, regardless of current state, including mid-sequence.
REQ-036 start asserted during reset SHALL be ignored; first honoured start is on a cycle with __rst_n=1 in StIdle.

Verification
REQ-037 Defaults, dwell={2,0,1,3}, start, loop_mode=0 -> step_pulse at run cycles 3,4,6,10; done on cycle 11; busy high cycles 1..10.
REQ-038 Same table, loop_mode=1 -> step_idx sequence 0,0,0,1,2,2,3,3,3,3,0...; no done; halt at cycle 14 -> aborted one cycle, state=StIdle.
REQ-039 Reset table, start -> each step 1 cycle, step_pulse 4 consecutive cycles, done next cycle.
REQ-040 cfg_we with cfg_idx=1 while busy -> dwell[1] unchanged, cfg_err one cycle; NUM_STEPS=3, cfg_idx=3 in StIdle -> cfg_err, no write.
REQ-041 start+halt same cycle in StIdle -> state stays 8'd0, no strobes; halt on a step's final cycle -> aborted, no step_pulse.
REQ-042 __rst_n=0 mid-step 2 -> next cycle state=8'd0, step_idx=0, busy=0, dwell table zero.
